// File: rtl/fifo_write_arbiter_if.sv
// Bundle of the FIFO write-port arbitration signals.
// "master" is the producer/FIFO side, "slave" is the arbiter itself.
interface fifo_write_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          busy;

  modport master (
    output req, req_last, req_data, fifo_full,
    input  grant, ack, fifo_write_en, fifo_data_in, busy
  );

  modport slave (
    input  req, req_last, req_data, fifo_full,
    output grant, ack, fifo_write_en, fifo_data_in, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant lasts for one burst, ended by a last-word flag, the BURST_MAX cap,
// or the owner withdrawing its request. Nothing is written while the FIFO is full.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input logic               clock,
  input logic               reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]  LastCnt = 4'(BURST_MAX - 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 busy_q;
  logic [3:0]           word_cnt_q;
  logic [IdxW-1:0]      rr_last_q;

  logic [IdxW-1:0]      owner_idx;
  logic [IdxW-1:0]      winner_idx;
  logic                 winner_found;
  logic                 owner_req;
  logic                 owner_last;
  logic                 owner_ack;
  logic [NUM_REQ-1:0]   ack_int;
  logic [DATA_WIDTH-1:0] owner_data;
  int unsigned          cand;

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_idx = IdxW'(i);
    end
  end

  // First asserted request scanning upward from rr_last+1 with wrap.
  always_comb begin
    winner_idx   = '0;
    winner_found = 1'b0;
    cand         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_last_q) + k) % NUM_REQ;
      if (!winner_found && bus.req[cand]) begin
        winner_idx   = IdxW'(cand);
        winner_found = 1'b1;
      end
    end
  end

  // Owner handshake and write-port drive; reset suppresses any write in its cycle.
  always_comb begin
    owner_req  = |(grant_q & bus.req);
    owner_last = |(grant_q & bus.req_last);
    owner_data = bus.req_data[32'(owner_idx) * DATA_WIDTH +: DATA_WIDTH];
    ack_int    = '0;
    if (state_q == StBurst && !reset && !bus.fifo_full) begin
      ack_int = grant_q & bus.req;
    end
    owner_ack         = |ack_int;
    bus.ack           = ack_int;
    bus.fifo_write_en = owner_ack;
    bus.fifo_data_in  = (grant_q != '0 && !reset) ? owner_data : '0;
    bus.grant         = grant_q;
    bus.busy          = busy_q;
  end

  // Arbitration FSM with registered grant/busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      word_cnt_q <= '0;
      rr_last_q  <= IdxW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (winner_found) begin
            state_q    <= StBurst;
            grant_q    <= NUM_REQ'(1) << winner_idx;
            busy_q     <= 1'b1;
            word_cnt_q <= '0;
          end
        end
        StBurst: begin
          if (!owner_req ||
              (owner_ack && (owner_last || word_cnt_q == LastCnt))) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
            rr_last_q  <= owner_idx;
          end else if (owner_ack) begin
            word_cnt_q <= word_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed bursts, then random producers, with
// every cycle compared against a burst-level reference model.
module tb_fifo_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int BM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner (-1 when idle), words sent in this burst, last owner.
  int m_own   = -1;
  int m_words = 0;
  int m_rr    = N - 1;
  logic [N-1:0]  exp_ack;
  logic [DW-1:0] wlog[$];

  logic [DW-1:0] pdat[N];
  int            seq[N];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic [N-1:0]  eg;
    logic [N-1:0]  ea;
    logic [DW-1:0] ed;
    logic          eb;
    bit            found;
    @(negedge clock);
    eg = '0; ea = '0; ed = '0; eb = 1'b0;
    if (m_own >= 0) begin
      eg[m_own] = 1'b1;
      eb        = 1'b1;
      if (!reset) begin
        ed = bus.req_data[m_own*DW +: DW];
        if (bus.req[m_own] && !bus.fifo_full) ea[m_own] = 1'b1;
      end
    end
    check("grant", 32'(bus.grant), 32'(eg));
    check("ack", 32'(bus.ack), 32'(ea));
    check("write_en", 32'(bus.fifo_write_en), 32'(|ea));
    check("data_in", 32'(bus.fifo_data_in), 32'(ed));
    check("busy", 32'(bus.busy), 32'(eb));
    if (bus.fifo_write_en === 1'b1) wlog.push_back(bus.fifo_data_in);
    exp_ack = ea;
    if (reset) begin
      m_own = -1; m_words = 0; m_rr = N - 1;
    end else if (m_own < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && bus.req[(m_rr + k) % N]) begin
          m_own = (m_rr + k) % N; m_words = 0; found = 1'b1;
        end
      end
    end else if (!bus.req[m_own]) begin
      m_rr = m_own; m_own = -1;
    end else if (ea[m_own]) begin
      m_words++;
      if (bus.req_last[m_own] || m_words == BM) begin
        m_rr = m_own; m_own = -1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cycle();
    reset = 1'b0;
    cycle();

    // R0 alone sends A1, A2, A3 (last).
    bus.req = 3'b001; bus.req_data[7:0] = 8'hA1;
    cycle(); cycle();
    bus.req_data[7:0] = 8'hA2; cycle();
    bus.req_data[7:0] = 8'hA3; bus.req_last = 3'b001; cycle();
    bus.req = '0; bus.req_last = '0; cycle();
    check("t1_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      check("t1_w0", 32'(wlog[0]), 32'hA1);
      check("t1_w1", 32'(wlog[1]), 32'hA2);
      check("t1_w2", 32'(wlog[2]), 32'hA3);
    end
    check("t1_grant_off", 32'(bus.grant), 32'd0);

    // Full stall after the 2nd word; word 3 lands when full falls.
    wlog.delete();
    bus.req = 3'b001; bus.req_data[7:0] = 8'hB1;
    cycle(); cycle();
    bus.req_data[7:0] = 8'hB2; cycle();
    bus.req_data[7:0] = 8'hB3; bus.fifo_full = 1'b1;
    repeat (3) cycle();
    bus.fifo_full = 1'b0; cycle();
    bus.req = '0; cycle(); cycle();
    check("t4_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) check("t4_w2", 32'(wlog[2]), 32'hB3);

    // Reset during word 2, then R0 wins against R1.
    bus.req = 3'b001; bus.req_data[7:0] = 8'hC1;
    cycle(); cycle();
    bus.req_data[7:0] = 8'hC2; reset = 1'b1; cycle();
    reset = 1'b0; bus.req = 3'b011;
    check("t5_grant_cleared", 32'(bus.grant), 32'd0);
    cycle(); cycle();
    check("t5_r0_first", 32'(bus.grant), 32'b001);
    bus.req = '0; cycle(); cycle();

    // Random producers honouring the hold-while-unacked rule.
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && !exp_ack[i] && $urandom_range(15) != 0) continue;
        if (bus.req[i] && exp_ack[i]) seq[i]++;
        pdat[i]                 = DW'((i << 6) | (seq[i] & 63));
        bus.req[i]              = 1'($urandom_range(1));
        bus.req_last[i]         = ($urandom_range(3) == 0);
        bus.req_data[i*DW +: DW] = pdat[i];
      end
      bus.fifo_full = ($urandom_range(3) == 0);
      reset         = ($urandom_range(199) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
